// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: performs an (N*WORDS)-bit add by stepping an external
// N-bit combinational adder one word per cycle, least-significant word first,
// and hands the assembled result off through a valid/ready handshake.
module wide_add_sequencer #(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   in_a,
  input  logic [N*WORDS-1:0]   in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WORDS-1:0][N-1:0] a_q, a_d;
  logic [WORDS-1:0][N-1:0] b_q, b_d;
  logic [WORDS-1:0][N-1:0] sum_q, sum_d;
  logic                    carry_q, carry_d;
  logic                    cout_q, cout_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    accept;

  // Handshake: ready in IDLE, or in DONE when the result is being taken this
  // cycle so a new request can chain directly into RUN.
  always_comb begin
    in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept    = in_valid && in_ready;
    out_valid = !rst && (state_q == DONE);
    out_sum   = sum_q;
    out_cout  = cout_q;
  end

  // Adder drive: current word and running carry during RUN, zeros otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (!rst && (state_q == RUN)) begin
      add_a   = a_q[idx_q];
      add_b   = b_q[idx_q];
      add_cin = carry_q;
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        if (idx_q == LAST_IDX) begin
          // Index wraps to 0 here so it stays constant when WORDS == 1.
          idx_d   = '0;
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            carry_d = in_cin;
            idx_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed vectors with a scoreboard of hand-computed
// results, a behavioural adder on the add_* ports, and a cycle-level monitor.
module tb_wide_add_sequencer;

  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             in_cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_sum;
  logic             out_cout;
  logic [N-1:0]     add_a, add_b, add_sum;
  logic             add_cin, add_cout;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t             exp_q[$];
  int               errors = 0;
  int               checks = 0;
  int unsigned      cyc = 0;
  logic [WORDS-1:0] cin_log = '0;

  wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Behavioural N-bit adder standing in for the attached combinational adder.
  assign {add_cout, add_sum} = (N+1)'(add_a) + (N+1)'(add_b) + (N+1)'(add_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: cycle model of IDLE/RUN/DONE, adder-port checks, scoreboard pop.
  int               m_state = 0;
  int               m_k = 0;
  logic [W-1:0]     m_a = '0;
  logic [W-1:0]     m_b = '0;
  logic             m_c = 1'b0;
  bit               rst_seen = 1'b0;

  always @(negedge clk) begin
    logic         exp_ready;
    logic [N-1:0] wa, wb;
    logic [N:0]   ws;
    int           nxt;
    exp_t         e;
    if (rst) begin
      chk("rst_out_valid", (W+1)'(out_valid), '0);
      chk("rst_in_ready", (W+1)'(in_ready), '0);
      chk("rst_add_ports", (W+1)'({add_a, add_b, add_cin}), '0);
      if (rst_seen) chk("rst_sum_cout", {out_cout, out_sum}, '0);
      exp_q.delete();
      m_state  = 0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) chk("post_rst_sum_cout", {out_cout, out_sum}, '0);
      rst_seen  = 1'b0;
      exp_ready = (m_state == 0) || ((m_state == 2) && out_ready);
      chk("in_ready", (W+1)'(in_ready), (W+1)'(exp_ready));
      chk("out_valid", (W+1)'(out_valid), (W+1)'(m_state == 2));
      nxt = m_state;
      if (m_state == 1) begin
        wa = m_a[m_k*N +: N];
        wb = m_b[m_k*N +: N];
        chk("add_a_word", (W+1)'(add_a), (W+1)'(wa));
        chk("add_b_word", (W+1)'(add_b), (W+1)'(wb));
        chk("add_cin_word", (W+1)'(add_cin), (W+1)'(m_c));
        cin_log[m_k] = add_cin;
        ws  = (N+1)'(wa) + (N+1)'(wb) + (N+1)'(m_c);
        m_c = ws[N];
        m_k++;
        if (m_k == WORDS) nxt = 2;
      end else begin
        chk("add_ports_idle", (W+1)'({add_a, add_b, add_cin}), '0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h with no pending request", out_sum);
        end else begin
          e = exp_q.pop_front();
          chk("out_sum", (W+1)'(out_sum), (W+1)'(e.sum));
          chk("out_cout", (W+1)'(out_cout), (W+1)'(e.cout));
        end
      end
      if ((m_state == 2) && out_ready) nxt = 0;
      if (in_valid && exp_ready) begin
        nxt     = 1;
        m_a     = in_a;
        m_b     = in_b;
        m_c     = in_cin;
        m_k     = 0;
        cin_log = '0;
      end
      m_state = nxt;
    end
  end

  // Issue one request, record its expected result, wait for acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [W-1:0] es, input logic ec, input bit hold);
    bit got;
    exp_q.push_back('{sum: es, cout: ec});
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected acceptance within 100 cycles");
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = '1;
      in_cin   = ~cin;
    end
  endtask

  // Wait until every scoreboard entry has been consumed.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", (W+1)'(in_ready), (W+1)'(1'b1));
    @(posedge clk);
    #1;

    // Carry ripples through every word.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    drain();
    chk("cin_seq_ripple", (W+1)'(cin_log), (W+1)'(4'b1110));

    // Mixed carries with carry-in set.
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
         64'h2222_2222_2222_2212, 1'b0, 1'b0);
    drain();
    chk("cin_seq_mixed", (W+1)'(cin_log), (W+1)'(4'b1111));

    // Backpressure: result held while out_ready is low, pending request refused.
    out_ready = 1'b0;
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
         64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);
    in_a     = 64'h5555_5555_5555_5555;
    in_b     = 64'hAAAA_AAAA_AAAA_AAAA;
    in_valid = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("bp_valid_rise", (W+1)'(seen), (W+1)'(1'b1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", (W+1)'(out_valid), (W+1)'(1'b1));
      chk("bp_out_sum", (W+1)'(out_sum), (W+1)'(64'h1234_5678_9ABC_DF00));
      chk("bp_out_cout", (W+1)'(out_cout), '0);
      chk("bp_in_ready", (W+1)'(in_ready), '0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_back_to_idle", (W+1)'({out_valid, in_ready}), (W+1)'(2'b01));
    chk("bp_scoreboard_empty", (W+1)'(exp_q.size()), '0);
    @(posedge clk);
    #1;

    // Back-to-back requests with the consumer always ready.
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
         64'h0, 1'b1, 1'b1);
    send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1,
         64'h0001_0000_0001_0001, 1'b0, 1'b1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
         64'h8000_0000_0000_0000, 1'b0, 1'b0);
    drain();

    // Reset during the second RUN cycle discards the operation.
    send(64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", (W+1)'(in_ready), (W+1)'(1'b1));
    @(posedge clk);
    #1;
    send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0,
         64'h0000_0001_0000_0000, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle sequencer that adds two wide operands (N·WORDS bits) by driving one N-bit combinational adder, such as the hybrid group-CLA, one word per cycle, least-significant word first. It sits directly upstream and downstream of that adder. It slices operands into N-bit words, presents them with the running carry on the adder input ports, and captures the adder's sum and carry-out on the following clock edge. It assembles the full result and hands it off through a valid/ready handshake.

## Interface
- `N`, 16, width of the attached adder (bits per word); N ≥ 1.
- `WORDS`, 4, number of words per operand; WORDS ≥ 1; total width W = N·WORDS.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  sequencer can accept an operand request.
- `in_a`, `in_b`  in  W  wide operands; sampled only on acceptance.
- `in_cin`  in  1  carry-in of the wide add.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  W  wide sum.
- `out_cout`  out  1  carry-out of the most-significant word.
- `add_a`, `add_b`  out  N  operand word to the adder.
- `add_cin`  out  1  carry to the adder.
- `add_sum`  in  N  adder sum; combinational and same-cycle response to add_*.
- `add_cout`  in  1  adder carry-out.

## Operation
- States: IDLE, RUN, DONE. Registers: a_reg, b_reg (W), sum_reg (W), carry_reg (1), idx (ceil(log2 WORDS), min 1 bit), cout_reg.
- Acceptance: in_valid && in_ready at a rising edge.
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)). This is combinational in out_ready.
- IDLE: on accept, latch in_a/in_b, set carry_reg = in_cin and idx = 0, and go to RUN.
- RUN, for word k = idx:
  - Drive add_a = a_reg[k·N +: N], add_b = b_reg[k·N +: N], add_cin = carry_reg.
  - On the edge: sum_reg[k·N +: N] ← add_sum, carry_reg ← add_cout, idx ← idx+1.
  - When k == WORDS-1: cout_reg ← add_cout, go to DONE.
- Outside RUN: add_a = 0, add_b = 0, add_cin = 0.
- DONE: out_valid = 1; out_sum = sum_reg; out_cout = cout_reg. These are held stable until out_ready.
  - On out_ready without a new accept, go to IDLE.
  - On out_ready with a same-cycle accept, latch the new operands and go straight to RUN (idx = 0).
- out_valid = (state==DONE). out_sum/out_cout keep their last value in IDLE/RUN, but out_valid qualifies them.
- Arithmetic: out_sum = (in_a + in_b + in_cin) mod 2^W; out_cout = bit W of the exact sum. No internal adder is used; all addition goes through the add_* ports.
- in_a/in_b changes after acceptance have no effect on the current operation.
- WORDS = 1: RUN lasts one cycle, and idx is constant 0.

## Timing
- Reset, while rst is high and on the first edge: state = IDLE, idx = 0, carry_reg = 0, sum_reg = 0, cout_reg = 0.
  - Outputs: out_valid = 0, out_sum = 0, out_cout = 0, in_ready = 0, add_* = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
- Accept at edge T: RUN covers cycles T..T+WORDS-1, i.e. word k is on add_* during the cycle after edge T+k.
  - out_valid rises after edge T+WORDS.
  - Latency is WORDS+1 cycles from the accept edge to the first cycle with out_valid high.
- Sustained throughput with out_ready = 1 and in_valid = 1: one result per WORDS+1 cycles.
- Backpressure: DONE holds indefinitely, and no request is accepted while out_ready = 0.
- Reset mid-RUN or in DONE: operation discarded, no out_valid pulse, and the state after reset is as above.
- in_valid during RUN is ignored (in_ready = 0). The requester holds it per the valid/ready rule.

## Test plan
- Carry across all words (N=16, WORDS=4), A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 -> out_sum=0, out_cout=1, out_valid exactly 5 cycles after the accept edge.
- Mixed carries, A=0x1234_5678_9ABC_DEF0, B=0x0FED_CBA9_8765_4321, cin=1:
  - out_sum=0x2222_2222_2222_2212, out_cout=0.
  - add_cin sequence across RUN cycles = 1,1,1,1.
- Adder port check: monitor add_a/add_b each RUN cycle -> LS word first, words 0..3 in order, all zeros outside RUN. Bench adder model is `add_sum,add_cout = add_a+add_b+add_cin`.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_sum, out_cout stable, in_ready=0. Raise out_ready -> one handshake, then IDLE.
- Back-to-back: in_valid=1, out_ready=1 continuously, 3 random operand pairs -> results every 5 cycles, each matching the exact reference sum, with in_ready high in each DONE cycle.
- Reset mid-operation: assert rst during the 2nd RUN cycle for 1 cycle -> no out_valid for that request, in_ready=1 the cycle after rst drops, and the next request completes correctly.
